snitch_hwloop_fetch: RTL
========================

Name: snitch_hwloop_fetch

Overview:
PC-generation and single-outstanding instruction-fetch stage directly upstream of the hardware-loop controller.
- Owns the architectural fetch PC and issues requests to the instruction memory port.
- Presents one instruction at a time to decode.
- Drives the hardware-loop controller's current-PC and valid inputs, and consumes its jump/target outputs to pick the next PC.
- Next-PC priority: flush > decode redirect > hardware-loop jump > sequential PC+4.

Parameters:
BOOT_ADDR, 32'h8000_0000, PC loaded at reset and fetched first after fetch_enable_i; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- fetch_enable_i  in  1  allows leaving IDLE and issuing new requests
- inst_addr_o  out  32  fetch address, word aligned
- inst_valid_o  out  1  fetch request valid
- inst_ready_i  in  1  memory accepts request
- inst_data_i  in  32  fetched instruction word
- inst_rvalid_i  in  1  response valid, one or more cycles after acceptance
- dec_valid_o  out  1  instruction available to decode
- dec_ready_i  in  1  decode consumes instruction
- dec_inst_o  out  32  held instruction
- dec_pc_o  out  32  PC of held instruction
- redirect_valid_i  in  1  branch/jump taken by the held instruction; sampled only on decode fire
- redirect_pc_i  in  32  redirect target
- flush_i  in  1  exception/CSR flush; usable in any state
- flush_pc_i  in  32  flush target
- hwloop_pc_o  out  32  current PC to the loop controller (always equals dec_pc_o)
- hwloop_valid_o  out  1  held instruction retires without redirect
- hwloop_jump_i  in  1  loop end reached
- hwloop_targ_addr_i  in  32  loop start address

Behaviour:
- Reset values:
  - State IDLE; pc_q = BOOT_ADDR; inst_q = 0; flush_pending_q = 0.
  - All valid outputs 0; address/data/pc outputs reflect registers (BOOT_ADDR, 0).
- IDLE:
  - inst_valid_o = 0, dec_valid_o = 0.
  - fetch_enable_i = 1 -> REQ next cycle.
  - flush_i loads pc_q <= flush_pc_i and stays IDLE.
- REQ:
  - inst_valid_o = 1, inst_addr_o = pc_q. Address and valid are held stable until inst_ready_i.
  - On inst_ready_i -> WAIT.
  - flush_i while in REQ: set flush_pending_q and latch the flush PC; the request is still completed.
- WAIT:
  - On inst_rvalid_i with flush_pending_q = 0: inst_q <= inst_data_i -> HOLD.
  - With flush_pending_q = 1: discard data, pc_q <= pending PC, clear pending -> REQ (or IDLE if fetch_enable_i = 0).
  - A flush arriving in WAIT sets pending. A flush coinciding with rvalid also discards.
- HOLD:
  - dec_valid_o = 1, dec_inst_o = inst_q, dec_pc_o = hwloop_pc_o = pc_q.
  - fire = dec_valid_o & dec_ready_i. On fire:
    - pc_q <= redirect_valid_i ? redirect_pc_i : hwloop_jump_i ? hwloop_targ_addr_i : pc_q + 4.
    - Go to REQ, or IDLE if fetch_enable_i = 0.
  - hwloop_valid_o = fire & ~redirect_valid_i & ~flush_i. This is combinational, the same cycle as fire.
  - flush_i in HOLD overrides fire: pc_q <= flush_pc_i -> REQ; no hwloop_valid_o; dec_valid_o may drop next cycle.
- Latency:
  - Decode fire to the next inst_valid_o: 1 cycle.
  - inst_rvalid_i to dec_valid_o: 1 cycle (registered).
- Arithmetic:
  - PC + 4 is 32-bit, wrapping at 32'hFFFF_FFFC -> 0.
  - Every PC load forces bits [1:0] to 0.
- At most one request is outstanding. No response is ever presented to decode twice.
- Asynchronous reset mid-transaction returns to IDLE. A late memory response after reset is ignored because the state is not WAIT.

Decomposition:
- Package snitch_hwloop_fetch_pkg:
  - State enum {IDLE, REQ, WAIT, HOLD}.
  - INSTR_BYTES = 4.
  - Function next_pc(flush, fpc, redir, rpc, jmp, tpc, pc), used by both RTL and testbench model.
- No sub-module; a single FSM with pc/inst/pending registers.

Test Plan:
- Sequential:
  - Stimulus: reset, fetch_enable_i = 1, memory ready/rvalid with 1-cycle latency, decode always ready.
  - Required: addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; hwloop_valid_o pulses once per instruction.
- Hardware loop:
  - Stimulus: hwloop_jump_i = 1 with target 0x8000_0010 while dec_pc_o = 0x8000_0020.
  - Required: next inst_addr_o = 0x8000_0010, hwloop_valid_o = 1 that cycle.
- Redirect vs loop:
  - Stimulus: redirect_valid_i = 1 (pc 0x9000_0000) and hwloop_jump_i = 1 on the same fire.
  - Required: next address 0x9000_0000, hwloop_valid_o = 0.
- Flush in WAIT:
  - Stimulus: flush to 0x0000_0100 while the response is outstanding.
  - Required: response data discarded, dec_valid_o stays 0, next request address 0x0000_0100.
- Backpressure:
  - Stimulus: inst_ready_i low for 3 cycles, dec_ready_i low for 2 cycles.
  - Required: inst_addr_o and dec_inst_o/dec_pc_o remain stable, no duplicate requests.
- Wrap and reset:
  - Stimulus: redirect to 0xFFFF_FFFC, then one sequential fetch. Separately, assert rst_ni low in WAIT.
  - Required: wrap fetch address 0x0000_0000. After reset: IDLE, all valids 0, pc_q = BOOT_ADDR.

Source files
------------

// File: rtl/snitch_hwloop_fetch_pkg.sv
// snitch_hwloop_fetch_pkg: shared state encoding and next-PC selection for the fetch stage
package snitch_hwloop_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  function automatic logic [31:0] next_pc(
    input logic        flush,
    input logic [31:0] fpc,
    input logic        redir,
    input logic [31:0] rpc,
    input logic        jmp,
    input logic [31:0] tpc,
    input logic [31:0] pc
  );
    logic [31:0] n;
    n = flush ? fpc : redir ? rpc : jmp ? tpc : pc + INSTR_BYTES;
    return {n[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/snitch_hwloop_fetch.sv
// snitch_hwloop_fetch: single-outstanding fetch FSM feeding decode and the hardware-loop controller
module snitch_hwloop_fetch
  import snitch_hwloop_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic [31:0] inst_data_i,
  input  logic        inst_rvalid_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_inst_o,
  output logic [31:0] dec_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] hwloop_pc_o,
  output logic        hwloop_valid_o,
  input  logic        hwloop_jump_i,
  input  logic [31:0] hwloop_targ_addr_i
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, flush_pc_q, flush_pc_d;
  logic        flush_pending_q, flush_pending_d, fire;
  assign inst_valid_o   = state_q == REQ;
  assign inst_addr_o    = pc_q;
  assign dec_valid_o    = state_q == HOLD;
  assign dec_inst_o     = inst_q;
  assign dec_pc_o       = pc_q;
  assign hwloop_pc_o    = pc_q;
  assign fire           = dec_valid_o & dec_ready_i;
  assign hwloop_valid_o = fire & ~redirect_valid_i & ~flush_i;
  // Next-state: a flush seen while a request is in flight is parked until its response drains
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    flush_pending_d = flush_pending_q;
    flush_pc_d      = flush_pc_q;
    case (state_q)
      IDLE: begin
        if (flush_i) pc_d = next_pc(1'b1, flush_pc_i, 1'b0, 32'd0, 1'b0, 32'd0, pc_q);
        if (fetch_enable_i) state_d = REQ;
      end
      REQ: begin
        if (flush_i) begin
          flush_pending_d = 1'b1;
          flush_pc_d      = flush_pc_i;
        end
        if (inst_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (inst_rvalid_i && (flush_i || flush_pending_q)) begin
          pc_d            = next_pc(1'b1, flush_i ? flush_pc_i : flush_pc_q, 1'b0, 32'd0, 1'b0, 32'd0, pc_q);
          flush_pending_d = 1'b0;
          state_d         = fetch_enable_i ? REQ : IDLE;
        end else if (inst_rvalid_i) begin
          inst_d  = inst_data_i;
          state_d = HOLD;
        end else if (flush_i) begin
          flush_pending_d = 1'b1;
          flush_pc_d      = flush_pc_i;
        end
      end
      HOLD: begin
        if (flush_i || fire) begin
          pc_d    = next_pc(flush_i, flush_pc_i, redirect_valid_i, redirect_pc_i,
                            hwloop_jump_i, hwloop_targ_addr_i, pc_q);
          state_d = (flush_i || fetch_enable_i) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      pc_q            <= {BOOT_ADDR[31:2], 2'b00};
      inst_q          <= '0;
      flush_pending_q <= 1'b0;
      flush_pc_q      <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
      flush_pending_q <= flush_pending_d;
      flush_pc_q      <= flush_pc_d;
    end
  end
endmodule
